// File: rtl/ram_arb_pkg.sv
// Shared definitions for the packet-RAM write-port arbiter: FSM encoding,
// requester index map and the width of the reported burst length.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   // Requester slots on the shared write port
   localparam int REQ_INIT   = 0;   // default-pattern loader
   localparam int REQ_UDP_RX = 1;   // UDP receive path
   localparam int REQ_ADC    = 2;   // ADC capture

   localparam int DLEN_W = 8;       // done_len width; longer bursts saturate

endpackage

// File: rtl/ram_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at rr_ptr and returns
// the first requester found as a one-hot vector plus its index.
module rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      rr_ptr,
   output logic [NREQ-1:0] pick,
   output logic [2:0]      pick_idx
);

   // Walk from the farthest slot back to rr_ptr so the nearest request wins last
   always_comb begin
      int k;
      pick     = '0;
      pick_idx = '0;
      k        = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = (int'(rr_ptr) + i) % NREQ;
         if (req[k]) begin
            pick     = '0;
            pick[k]  = 1'b1;
            pick_idx = 3'(k);
         end
      end
   end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Write-port arbiter for the 512x32 packet RAM. One requester owns the port
// for a whole burst; the next owner is chosen round-robin. RAM strobe, address
// and data are registered. Each finished burst reports owner and length.
// Optional build macro RAM_WR_ARB_PRIO0_EN: requester 0 wins every IDLE
// arbitration it takes part in (no preemption of a running burst).
module ram_wr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ      = 3,
   parameter int AW        = 9,
   parameter int DW        = 32,
   parameter int MAX_BURST = 128,
   parameter int IDLE_TO   = 16
) (
   input  logic               e_rxc,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    wr_en,
   input  logic [NREQ-1:0]    wr_last,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    gnt,
   output logic               ram_wea,
   output logic [AW-1:0]      ram_addra,
   output logic [DW-1:0]      ram_dina,
   output logic               busy,
   output logic               done,
   output logic [2:0]         done_id,
   output logic [7:0]         done_len,
   output logic               err_forced
);

   // Burst counter must hold MAX_BURST and at least the 8-bit report range
   localparam int CW = ($clog2(MAX_BURST + 1) > DLEN_W) ? $clog2(MAX_BURST + 1) : DLEN_W;
   localparam int IW = $clog2(IDLE_TO + 1);

   arb_state_t      st, nxt;
   logic [NREQ-1:0] rr_req, pick_oh, win_oh;
   logic [2:0]      pick_idx, win_idx, g_idx, rr_ptr;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [IW-1:0]   idle_cnt;
   logic            load_gnt, rel, force_err;
   logic            wr_hit, wr_lst, req_hit;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

`ifdef RAM_WR_ARB_PRIO0_EN
   // Requester 0 bypasses the rotation; the others still share round-robin
   assign rr_req  = {req[NREQ-1:1], 1'b0};
   assign win_oh  = req[REQ_INIT] ? NREQ'(1) : pick_oh;
   assign win_idx = req[REQ_INIT] ? 3'd0 : pick_idx;
`else
   assign rr_req  = req;
   assign win_oh  = pick_oh;
   assign win_idx = pick_idx;
`endif

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req      (rr_req),
      .rr_ptr   (rr_ptr),
      .pick     (pick_oh),
      .pick_idx (pick_idx)
   );

   // Route the granted requester's address/data toward the RAM register
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            sel_addr = sel_addr | wr_addr[k*AW +: AW];
            sel_data = sel_data | wr_data[k*DW +: DW];
         end
      end
   end

   // Strobes from non-granted requesters are masked out by the grant vector
   assign wr_hit  = (st == GRANT) && |(wr_en & gnt);
   assign wr_lst  = wr_hit && |(wr_en & wr_last & gnt);
   assign req_hit = |(req & gnt);
   assign cnt_nx  = cnt + CW'(wr_hit);
   assign busy    = (st != IDLE);

   // State register
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) st <= IDLE;
      else          st <= nxt;
   end

   // Next state and release decision; an explicit last outranks the size limit
   always_comb begin
      nxt       = st;
      load_gnt  = 1'b0;
      rel       = 1'b0;
      force_err = 1'b0;
      case (st)
         IDLE: begin
            if (|req) begin
               nxt      = GRANT;
               load_gnt = 1'b1;
            end
         end
         GRANT: begin
            if (wr_lst) begin
               rel = 1'b1;
            end else if (!req_hit && !wr_hit) begin
               rel = 1'b1;
            end else if (wr_hit && cnt_nx >= CW'(MAX_BURST)) begin
               rel       = 1'b1;
               force_err = 1'b1;
            end else if (!wr_hit && idle_cnt >= IW'(IDLE_TO - 1)) begin
               rel       = 1'b1;
               force_err = 1'b1;
            end
            if (rel) nxt = RELEASE;
         end
         RELEASE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Grant, counters, RAM port register and burst report
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         gnt        <= '0;
         g_idx      <= '0;
         rr_ptr     <= '0;
         cnt        <= '0;
         idle_cnt   <= '0;
         ram_wea    <= 1'b0;
         ram_addra  <= '0;
         ram_dina   <= '0;
         done       <= 1'b0;
         done_id    <= '0;
         done_len   <= '0;
         err_forced <= 1'b0;
      end else begin
         ram_wea <= wr_hit;
         if (wr_hit) begin
            ram_addra <= sel_addr;
            ram_dina  <= sel_data;
         end
         if (load_gnt) begin
            gnt      <= win_oh;
            g_idx    <= win_idx;
            cnt      <= '0;
            idle_cnt <= '0;
         end else begin
            if (rel) gnt <= '0;
            cnt <= cnt_nx;
            if (wr_hit)            idle_cnt <= '0;
            else if (st == GRANT)  idle_cnt <= idle_cnt + 1'b1;
         end
         done       <= rel;
         done_id    <= rel ? g_idx : 3'd0;
         done_len   <= !rel ? 8'd0 : (cnt_nx > CW'(255)) ? 8'hFF : cnt_nx[DLEN_W-1:0];
         err_forced <= err_forced | force_err;
         if (st == RELEASE)
            rr_ptr <= (g_idx == 3'(NREQ - 1)) ? 3'd0 : g_idx + 3'd1;
      end
   end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Self-checking bench for ram_wr_arbiter: table of single bursts, then
// fairness, intruder, overrun, stall and mid-burst reset sequences. RAM writes
// and burst reports are predicted into queues and checked by a monitor.
module tb_ram_wr_arbiter;
   localparam int NREQ = 3, AW = 9, DW = 32, MAX_BURST = 128, IDLE_TO = 16;

   logic               e_rxc = 1'b0;
   logic               reset_n = 1'b0;
   logic [NREQ-1:0]    req = '0, wr_en = '0, wr_last = '0;
   logic [NREQ*AW-1:0] wr_addr = '0;
   logic [NREQ*DW-1:0] wr_data = '0;
   logic [NREQ-1:0]    gnt;
   logic               ram_wea, busy, done, err_forced;
   logic [AW-1:0]      ram_addra;
   logic [DW-1:0]      ram_dina;
   logic [2:0]         done_id;
   logic [7:0]         done_len;

   int checks = 0, errors = 0;
   int m_rr = 0;

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { int id; int len; } done_t;
   typedef struct { int r; int n; bit last; logic [AW-1:0] base; int exp_len; bit exp_err; bit chk_lat; } vec_t;

   wr_t   wq[$];
   done_t dq[$];
   wr_t   mw;
   done_t md;

   always #5 e_rxc = ~e_rxc;

   ram_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .IDLE_TO(IDLE_TO)) dut (
      .e_rxc(e_rxc), .reset_n(reset_n), .req(req), .wr_en(wr_en), .wr_last(wr_last),
      .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt), .ram_wea(ram_wea),
      .ram_addra(ram_addra), .ram_dina(ram_dina), .busy(busy), .done(done),
      .done_id(done_id), .done_len(done_len), .err_forced(err_forced)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge e_rxc);
      #1;
   endtask

   // Reference arbitration: scan from the model pointer
   function automatic int model_pick(input logic [NREQ-1:0] r);
      int k;
`ifdef RAM_WR_ARB_PRIO0_EN
      if (r[0]) return 0;
      r[0] = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         k = (m_rr + i) % NREQ;
         if (r[k]) return k;
      end
      return 0;
   endfunction

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge e_rxc) begin
      if (reset_n) begin
         if (ram_wea) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, want no write", ram_addra, ram_dina);
            end else begin
               mw = wq.pop_front();
               chk("ram_addra", ram_addra, mw.addr);
               chk("ram_dina", ram_dina, mw.data);
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: id %0d len %0d, want no done", done_id, done_len);
            end else begin
               md = dq.pop_front();
               chk("done_id", done_id, md.id);
               chk("done_len", done_len, md.len);
            end
         end
      end
   end

   task automatic wait_gnt(input int exp, input bit chk_lat);
      int lat;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (gnt == '0 && lat < 12);
      chk("gnt", gnt, longint'(1) << exp);
      if (chk_lat) chk("gnt_latency", lat, 1);
   endtask

   task automatic run_burst(input vec_t v);
      wr_t   w;
      done_t d;
      req[v.r] = 1'b1;
      wait_gnt(v.r, v.chk_lat);
      req[v.r] = 1'b0;
      d.id = v.r; d.len = v.exp_len;
      dq.push_back(d);
      for (int i = 0; i < v.n; i++) begin
         wr_en[v.r]   = 1'b1;
         wr_last[v.r] = v.last && (i == v.n - 1);
         wr_addr[v.r*AW +: AW] = v.base + AW'(i);
         wr_data[v.r*DW +: DW] = $urandom;
         w.addr = wr_addr[v.r*AW +: AW];
         w.data = wr_data[v.r*DW +: DW];
         if (i < MAX_BURST) wq.push_back(w);
         tick();
      end
      wr_en[v.r] = 1'b0; wr_last[v.r] = 1'b0;
      repeat (3) tick();
      chk("err_forced", err_forced, v.exp_err);
      chk("busy_idle", busy, 0);
      m_rr = (v.r + 1) % NREQ;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl[4];
      wr_t   w;
      done_t d;
      int    e;
      tbl[0] = '{1, 4, 1'b1, 9'h010, 4, 1'b0, 1'b1};   // single burst, last on word 4
      tbl[1] = '{1, 0, 1'b0, 9'h000, 0, 1'b0, 1'b1};   // req drops with no write
      tbl[2] = '{0, 1, 1'b1, 9'h1F0, 1, 1'b0, 1'b1};   // one-word burst
      tbl[3] = '{2, 3, 1'b1, 9'h1FE, 3, 1'b0, 1'b1};   // address wraps past 0x1FF

      // Reset state
      repeat (2) tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_ram_wea", ram_wea, 0);
      chk("rst_ram_addra", ram_addra, 0);
      chk("rst_done", done, 0);
      chk("rst_done_len", done_len, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_forced, 0);
      reset_n = 1'b1;
      tick();

      foreach (tbl[i]) run_burst(tbl[i]);

      // Fairness with all requests held, 2-word bursts
      req = '1;
      for (int k = 0; k < 6; k++) begin
         e = model_pick(req);
         wait_gnt(e, 1'b0);
         d.id = e; d.len = 2;
         dq.push_back(d);
         for (int i = 0; i < 2; i++) begin
            wr_en[e] = 1'b1; wr_last[e] = (i == 1);
            wr_addr[e*AW +: AW] = 9'h080 + AW'(k*2 + i);
            wr_data[e*DW +: DW] = $urandom;
            w.addr = wr_addr[e*AW +: AW]; w.data = wr_data[e*DW +: DW];
            wq.push_back(w);
            tick();
         end
         wr_en[e] = 1'b0; wr_last[e] = 1'b0;
         m_rr = (e + 1) % NREQ;
      end
      req = '0;
      repeat (3) tick();

      // Intruder: requester 0 strobes to 0x1FF while 2 holds the grant
      wr_en[0] = 1'b1; wr_addr[0 +: AW] = 9'h1FF; wr_data[0 +: DW] = 32'hDEAD_BEEF;
      run_burst('{2, 3, 1'b1, 9'h020, 3, 1'b0, 1'b1});
      wr_en[0] = 1'b0;

      // Overrun: 130 words, no last
      run_burst('{0, 130, 1'b0, 9'h100, 128, 1'b1, 1'b0});

      // Stall: one write, then silence until the idle timeout
      req[1] = 1'b1;
      wait_gnt(1, 1'b0);
      d.id = 1; d.len = 1;
      dq.push_back(d);
      wr_en[1] = 1'b1; wr_addr[1*AW +: AW] = 9'h0AA; wr_data[1*DW +: DW] = $urandom;
      w.addr = 9'h0AA; w.data = wr_data[1*DW +: DW];
      wq.push_back(w);
      tick();
      wr_en[1] = 1'b0;
      repeat (15) tick();
      chk("stall_gnt_held", gnt, 3'b010);
      tick();
      chk("stall_gnt_released", gnt, 0);
      chk("stall_done", done, 1);
      req[1] = 1'b0;
      repeat (3) tick();
      chk("err_sticky", err_forced, 1);
      m_rr = 2;

      // Reset in the middle of an 8-word burst, during word 3
      req[0] = 1'b1;
      wait_gnt(0, 1'b0);
      req[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr_en[0] = 1'b1;
         wr_addr[0 +: AW] = 9'h060 + AW'(i);
         wr_data[0 +: DW] = $urandom;
         w.addr = wr_addr[0 +: AW]; w.data = wr_data[0 +: DW];
         wq.push_back(w);
         tick();
      end
      wr_addr[0 +: AW] = 9'h062;
      #5;
      reset_n = 1'b0;
      #1;
      chk("mrst_gnt", gnt, 0);
      chk("mrst_ram_wea", ram_wea, 0);
      chk("mrst_done", done, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_err", err_forced, 0);
      wr_en[0] = 1'b0;
      tick();
      reset_n = 1'b1;
      m_rr = 0;
      run_burst('{2, 2, 1'b1, 9'h030, 2, 1'b0, 1'b1});

      repeat (2) tick();
      chk("pending_writes", wq.size(), 0);
      chk("pending_done", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
